// File: rtl/fragment_rr_arbiter_pkg.sv
// Shared types and helpers for the fragment round-robin arbiter.
package fragment_rr_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  function automatic int unsigned clip_size(input int unsigned size, input int unsigned s_max);
    return (size > s_max) ? s_max : size;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester found cyclically after i_ptr.
module rr_priority_picker #(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0]         i_req,
  input  logic [$clog2(N_SRC)-1:0] i_ptr,
  output logic [N_SRC-1:0]         o_gnt,
  output logic [$clog2(N_SRC)-1:0] o_idx,
  output logic                     o_any
);

  localparam int IW = $clog2(N_SRC);

  logic [IW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester wins last.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    cand  = '0;
    for (int off = N_SRC; off >= 1; off--) begin
      cand = IW'((int'(i_ptr) + off) % N_SRC);
      if (i_req[cand]) begin
        o_gnt       = '0;
        o_gnt[cand] = 1'b1;
        o_idx       = cand;
        o_any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fragment_rr_arbiter.sv
// Packet-granular round-robin arbiter feeding one fragment packer through a 1-deep slot.
// Optional per-source counters: define FRAGMENT_RR_ARBITER_STATS_EN.
module fragment_rr_arbiter
  import fragment_rr_arbiter_pkg::*;
#(
  parameter int  N_SRC    = 4,
  parameter int  S_MAX_IN = 4,
  parameter type T        = logic
) (
  input  logic                                      i_clk,
  input  logic                                      i_sync_rst,
  input  logic [N_SRC-1:0]                          i_us_valid,
  input  logic [N_SRC-1:0][$clog2(S_MAX_IN+1)-1:0]  i_us_size,
  input  T     [N_SRC-1:0][S_MAX_IN-1:0]            i_us_frag,
  input  logic [N_SRC-1:0]                          i_us_last,
  output logic [N_SRC-1:0]                          o_us_ready,
  input  logic                                      i_ds_ready,
  output logic                                      o_ds_valid,
  output logic [$clog2(S_MAX_IN+1)-1:0]             o_ds_size,
  output T     [S_MAX_IN-1:0]                       o_ds_frag,
  output logic                                      o_ds_last,
  output logic [$clog2(N_SRC)-1:0]                  o_ds_src_id
`ifdef FRAGMENT_RR_ARBITER_STATS_EN
  ,
  output logic [N_SRC-1:0][31:0]                    o_stat_elem_cnt,
  output logic [N_SRC-1:0][31:0]                    o_stat_pkt_cnt
`endif
);

  localparam int SW = $clog2(S_MAX_IN+1);
  localparam int IW = $clog2(N_SRC);

  state_e              state_q, state_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]       lock_id_q, lock_id_d;

  logic                ds_valid_q, ds_valid_d;
  logic [SW-1:0]       ds_size_q, ds_size_d;
  T [S_MAX_IN-1:0]     ds_frag_q, ds_frag_d;
  logic                ds_last_q, ds_last_d;
  logic [IW-1:0]       ds_src_id_q, ds_src_id_d;

  logic                slot_free;
  logic                accept;
  logic                pick_any;
  logic [N_SRC-1:0]    pick_gnt;
  logic [IW-1:0]       pick_idx;
  logic [IW-1:0]       sel_id;
  logic [SW-1:0]       sel_size;
  logic [N_SRC-1:0]    us_ready;

  rr_priority_picker #(.N_SRC(N_SRC)) u_picker (
    .i_req (i_us_valid),
    .i_ptr (rr_ptr_q),
    .o_gnt (pick_gnt),
    .o_idx (pick_idx),
    .o_any (pick_any)
  );

  assign slot_free = !ds_valid_q || i_ds_ready;
  assign sel_id    = (state_q == LOCKED) ? lock_id_q : pick_idx;
  assign sel_size  = SW'(clip_size(32'(i_us_size[sel_id]), $unsigned(S_MAX_IN)));
  assign accept    = |(us_ready & i_us_valid);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= IW'(N_SRC-1);
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_id_q <= lock_id_d;
    end
  end

  // Next state: the lock opens on a non-last accept and closes on the last one
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_id_d = lock_id_q;
    if (accept) begin
      if (i_us_last[sel_id]) begin
        state_d  = IDLE;
        rr_ptr_d = sel_id;
      end else begin
        state_d   = LOCKED;
        lock_id_d = sel_id;
      end
    end
  end

  // Output decode: ready is a zero-cycle grant, gated during reset
  always_comb begin
    us_ready = '0;
    if (!i_sync_rst && slot_free) begin
      if (state_q == LOCKED) us_ready[lock_id_q] = 1'b1;
      else if (pick_any)     us_ready = pick_gnt;
    end
  end

  always_comb begin
    ds_valid_d  = ds_valid_q && !i_ds_ready;
    ds_size_d   = ds_size_q;
    ds_frag_d   = ds_frag_q;
    ds_last_d   = ds_last_q;
    ds_src_id_d = ds_src_id_q;
    if (accept) begin
      ds_valid_d  = 1'b1;
      ds_size_d   = sel_size;
      ds_frag_d   = i_us_frag[sel_id];
      ds_last_d   = i_us_last[sel_id];
      ds_src_id_d = sel_id;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      ds_valid_q  <= 1'b0;
      ds_size_q   <= '0;
      ds_frag_q   <= '0;
      ds_last_q   <= 1'b0;
      ds_src_id_q <= '0;
    end else begin
      ds_valid_q  <= ds_valid_d;
      ds_size_q   <= ds_size_d;
      ds_frag_q   <= ds_frag_d;
      ds_last_q   <= ds_last_d;
      ds_src_id_q <= ds_src_id_d;
    end
  end

  assign o_us_ready  = us_ready;
  assign o_ds_valid  = ds_valid_q;
  assign o_ds_size   = ds_size_q;
  assign o_ds_frag   = ds_frag_q;
  assign o_ds_last   = ds_last_q;
  assign o_ds_src_id = ds_src_id_q;

`ifdef FRAGMENT_RR_ARBITER_STATS_EN
  logic [N_SRC-1:0][31:0] stat_elem_cnt_q, stat_elem_cnt_d;
  logic [N_SRC-1:0][31:0] stat_pkt_cnt_q, stat_pkt_cnt_d;
  logic [32:0]            elem_sum;

  // Saturating counters; the 33-bit sum exposes the overflow
  always_comb begin
    stat_elem_cnt_d = stat_elem_cnt_q;
    stat_pkt_cnt_d  = stat_pkt_cnt_q;
    elem_sum        = {1'b0, stat_elem_cnt_q[sel_id]} + 33'(sel_size);
    if (accept) begin
      stat_elem_cnt_d[sel_id] = elem_sum[32] ? '1 : elem_sum[31:0];
      if (i_us_last[sel_id] && (stat_pkt_cnt_q[sel_id] != '1))
        stat_pkt_cnt_d[sel_id] = stat_pkt_cnt_q[sel_id] + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      stat_elem_cnt_q <= '0;
      stat_pkt_cnt_q  <= '0;
    end else begin
      stat_elem_cnt_q <= stat_elem_cnt_d;
      stat_pkt_cnt_q  <= stat_pkt_cnt_d;
    end
  end

  assign o_stat_elem_cnt = stat_elem_cnt_q;
  assign o_stat_pkt_cnt  = stat_pkt_cnt_q;
`endif

endmodule

// File: tb/tb_fragment_rr_arbiter.sv
// Directed bench for fragment_rr_arbiter: grant order, packet lock, backpressure, clipping, reset.
module tb_fragment_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [3:0]            us_valid, us_last, us_ready;
  logic [3:0][2:0]       us_size;
  logic [3:0][3:0][7:0]  us_frag;
  logic                  ds_ready, ds_valid, ds_last;
  logic [2:0]            ds_size;
  logic [3:0][7:0]       ds_frag;
  logic [1:0]            ds_src_id;

  int checks   = 0;
  int failures = 0;

  fragment_rr_arbiter #(.N_SRC(4), .S_MAX_IN(4), .T(logic [7:0])) dut (
    .i_clk       (clk),
    .i_sync_rst  (rst),
    .i_us_valid  (us_valid),
    .i_us_size   (us_size),
    .i_us_frag   (us_frag),
    .i_us_last   (us_last),
    .o_us_ready  (us_ready),
    .i_ds_ready  (ds_ready),
    .o_ds_valid  (ds_valid),
    .o_ds_size   (ds_size),
    .o_ds_frag   (ds_frag),
    .o_ds_last   (ds_last),
    .o_ds_src_id (ds_src_id)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_ds(input string tag, input logic v, input int id, input int sz,
                        input logic l, input logic [31:0] f);
    chk({tag, ".valid"}, 64'(ds_valid), 64'(v));
    if (v) begin
      chk({tag, ".src"},  64'(ds_src_id), 64'(id));
      chk({tag, ".size"}, 64'(ds_size),   64'(sz));
      chk({tag, ".last"}, 64'(ds_last),   64'(l));
      chk({tag, ".frag"}, 64'(ds_frag),   64'(f));
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    #3;
  endtask

  task automatic set_src(input int s, input logic v, input int sz, input logic l, input logic [31:0] f);
    us_valid[s] = v;
    us_size[s]  = 3'(sz);
    us_last[s]  = l;
    us_frag[s]  = f;
  endtask

  initial begin
    rst = 1'b1; ds_ready = 1'b1;
    us_valid = '0; us_last = '0; us_size = '0; us_frag = '0;
    set_src(0, 1'b1, 1, 1'b1, 32'h0000_00A1);
    cyc; cyc; cyc;
    smp;
    chk("rst.ready", 64'(us_ready), 64'h0);
    chk("rst.valid", 64'(ds_valid), 64'h0);
    chk("rst.size",  64'(ds_size),  64'h0);
    chk("rst.frag",  64'(ds_frag),  64'h0);
    chk("rst.last",  64'(ds_last),  64'h0);
    chk("rst.src",   64'(ds_src_id), 64'h0);

    // sources 0 and 2 both single-fragment: 0 first, then 2
    cyc; rst = 1'b0;
    set_src(2, 1'b1, 2, 1'b1, 32'h0000_B2B1);
    smp; chk("t1.ready0", 64'(us_ready), 64'b0001); chk("t1.dsv0", 64'(ds_valid), 64'h0);
    cyc; set_src(0, 1'b0, 0, 1'b0, 32'h0);
    smp; chk("t1.ready1", 64'(us_ready), 64'b0100); chk_ds("t1.o0", 1'b1, 0, 1, 1'b1, 32'h0000_00A1);
    cyc; set_src(2, 1'b0, 0, 1'b0, 32'h0);
    smp; chk("t1.ready2", 64'(us_ready), 64'b0000); chk_ds("t1.o2", 1'b1, 2, 2, 1'b1, 32'h0000_B2B1);
    cyc; smp; chk_ds("t1.idle", 1'b0, 0, 0, 1'b0, 32'h0);

    // source 1 three-fragment packet while source 0 waits
    set_src(1, 1'b1, 4, 1'b0, 32'h1010_1010);
    smp; chk("t2.ready0", 64'(us_ready), 64'b0010);
    cyc; set_src(1, 1'b1, 4, 1'b0, 32'h1111_1111); set_src(0, 1'b1, 3, 1'b1, 32'h0000_0F00);
    smp; chk("t2.ready1", 64'(us_ready), 64'b0010); chk_ds("t2.f0", 1'b1, 1, 4, 1'b0, 32'h1010_1010);
    cyc; set_src(1, 1'b1, 2, 1'b1, 32'h1212_1212);
    smp; chk("t2.ready2", 64'(us_ready), 64'b0010); chk_ds("t2.f1", 1'b1, 1, 4, 1'b0, 32'h1111_1111);
    cyc; set_src(1, 1'b0, 0, 1'b0, 32'h0);
    smp; chk("t2.ready3", 64'(us_ready), 64'b0001); chk_ds("t2.f2", 1'b1, 1, 2, 1'b1, 32'h1212_1212);
    cyc; set_src(0, 1'b0, 0, 1'b0, 32'h0);
    smp; chk("t2.ready4", 64'(us_ready), 64'b0000); chk_ds("t2.s0", 1'b1, 0, 3, 1'b1, 32'h0000_0F00);
    cyc; smp; chk_ds("t2.idle", 1'b0, 0, 0, 1'b0, 32'h0);

    // fairness after a fresh reset: 0,1,2,3,0,1 with no bubbles
    rst = 1'b1;
    cyc; rst = 1'b0;
    for (int s = 0; s < 4; s++) set_src(s, 1'b1, s + 1, 1'b1, 32'hC0C0_C0C0 + 32'(s));
    for (int k = 0; k < 6; k++) begin
      smp;
      chk($sformatf("t3.ready%0d", k), 64'(us_ready), 64'(4'b0001 << (k % 4)));
      if (k > 0)
        chk_ds($sformatf("t3.o%0d", k), 1'b1, (k - 1) % 4, ((k - 1) % 4) + 1, 1'b1,
               32'hC0C0_C0C0 + 32'((k - 1) % 4));
      cyc;
    end
    us_valid = '0;
    smp; chk("t3.readyE", 64'(us_ready), 64'h0); chk_ds("t3.o6", 1'b1, 1, 2, 1'b1, 32'hC0C0_C0C1);
    cyc; smp; chk_ds("t3.idle", 1'b0, 0, 0, 1'b0, 32'h0);

    // backpressure 1,0,0,1 mid-packet on source 3
    set_src(3, 1'b1, 4, 1'b0, 32'h3030_3030); ds_ready = 1'b1;
    smp; chk("t4.ready0", 64'(us_ready), 64'b1000);
    cyc; set_src(3, 1'b1, 4, 1'b0, 32'h3131_3131); ds_ready = 1'b0;
    smp; chk("t4.ready1", 64'(us_ready), 64'b0000); chk_ds("t4.h1", 1'b1, 3, 4, 1'b0, 32'h3030_3030);
    cyc;
    smp; chk("t4.ready2", 64'(us_ready), 64'b0000); chk_ds("t4.h2", 1'b1, 3, 4, 1'b0, 32'h3030_3030);
    cyc; ds_ready = 1'b1;
    smp; chk("t4.ready3", 64'(us_ready), 64'b1000); chk_ds("t4.h3", 1'b1, 3, 4, 1'b0, 32'h3030_3030);
    cyc; set_src(3, 1'b1, 1, 1'b1, 32'h3232_3232);
    smp; chk("t4.ready4", 64'(us_ready), 64'b1000); chk_ds("t4.f1", 1'b1, 3, 4, 1'b0, 32'h3131_3131);
    cyc; set_src(3, 1'b0, 0, 1'b0, 32'h0);
    smp; chk("t4.ready5", 64'(us_ready), 64'b0000); chk_ds("t4.f2", 1'b1, 3, 1, 1'b1, 32'h3232_3232);
    cyc; smp; chk_ds("t4.idle", 1'b0, 0, 0, 1'b0, 32'h0);

    // size clipping and zero-size last marker releasing the lock
    set_src(2, 1'b1, 7, 1'b0, 32'h2020_2020);
    smp; chk("t5.ready0", 64'(us_ready), 64'b0100);
    cyc; set_src(2, 1'b1, 0, 1'b1, 32'h2121_2121); set_src(0, 1'b1, 1, 1'b1, 32'h0000_0001);
    smp; chk("t5.ready1", 64'(us_ready), 64'b0100); chk_ds("t5.clip", 1'b1, 2, 4, 1'b0, 32'h2020_2020);
    cyc; set_src(2, 1'b0, 0, 1'b0, 32'h0);
    smp; chk("t5.ready2", 64'(us_ready), 64'b0001); chk_ds("t5.zero", 1'b1, 2, 0, 1'b1, 32'h2121_2121);
    cyc; set_src(0, 1'b0, 0, 1'b0, 32'h0);
    smp; chk("t5.ready3", 64'(us_ready), 64'b0000); chk_ds("t5.s0", 1'b1, 0, 1, 1'b1, 32'h0000_0001);
    cyc; smp; chk_ds("t5.idle", 1'b0, 0, 0, 1'b0, 32'h0);

    // reset while locked on source 2 with a held fragment
    set_src(2, 1'b1, 3, 1'b0, 32'h2222_2222);
    smp; chk("t6.ready0", 64'(us_ready), 64'b0100);
    cyc; ds_ready = 1'b0;
    smp; chk("t6.ready1", 64'(us_ready), 64'b0000); chk_ds("t6.held", 1'b1, 2, 3, 1'b0, 32'h2222_2222);
    rst = 1'b1; ds_ready = 1'b1; set_src(0, 1'b1, 1, 1'b1, 32'h0000_0002); set_src(2, 1'b1, 1, 1'b1, 32'h2323_2323);
    #1; chk("t6.rstgate", 64'(us_ready), 64'b0000);
    cyc;
    smp; chk("t6.rst.ready", 64'(us_ready), 64'b0000); chk_ds("t6.rst", 1'b0, 0, 0, 1'b0, 32'h0);
    chk("t6.rst.src", 64'(ds_src_id), 64'h0);
    cyc; rst = 1'b0;
    smp; chk("t6.ready2", 64'(us_ready), 64'b0001);
    cyc; set_src(0, 1'b0, 0, 1'b0, 32'h0);
    smp; chk("t6.ready3", 64'(us_ready), 64'b0100); chk_ds("t6.s0", 1'b1, 0, 1, 1'b1, 32'h0000_0002);
    cyc; set_src(2, 1'b0, 0, 1'b0, 32'h0);
    smp; chk_ds("t6.s2", 1'b1, 2, 1, 1'b1, 32'h2323_2323);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fragment_rr_arbiter.md
Name: fragment_rr_arbiter

Overview:
- Shares one fragment-to-chunk packer input between N_SRC upstream fragment sources.
- Round-robin arbitration at packet granularity: once a source is granted, it keeps the packer until its fragment flagged last is accepted. Fragments of different packets never interleave.
- Output is one register stage (1-cycle latency) driving the packer's fragment valid/size/data inputs and taking the packer's ready.
- Forwards source ID and last flag alongside each fragment for downstream bookkeeping.

Parameters:
- N_SRC, 4, number of upstream sources (>=2).
- S_MAX_IN, 4, max fragment size in elements; must match the packer's S_MAX_IN.
- T, logic, element data type.

Ports:
- i_clk  in  1  clock.
- i_sync_rst  in  1  synchronous active-high reset.
- i_us_valid  in  [N_SRC]  per-source fragment valid.
- i_us_size  in  [N_SRC][$clog2(S_MAX_IN+1)]  per-source fragment size; values above S_MAX_IN are clipped to S_MAX_IN.
- i_us_frag  in  T [N_SRC][S_MAX_IN]  per-source fragment elements.
- i_us_last  in  [N_SRC]  fragment ends the packet.
- o_us_ready  out  [N_SRC]  per-source ready.
- i_ds_ready  in  1  packer ready.
- o_ds_valid  out  1  fragment valid toward packer.
- o_ds_size  out  $clog2(S_MAX_IN+1)  clipped fragment size.
- o_ds_frag  out  T [S_MAX_IN]  fragment elements.
- o_ds_last  out  1  last flag of the forwarded fragment.
- o_ds_src_id  out  $clog2(N_SRC)  originating source.

Behaviour:
- Reset values:
  - o_ds_valid=0, o_us_ready=0, o_ds_size=0, o_ds_frag=all 0, o_ds_last=0, o_ds_src_id=0.
  - State IDLE; r_rr_ptr=N_SRC-1, so source 0 has top priority after reset.
  - All outputs are also held at these values while i_sync_rst=1.
- Output stage:
  - Slot accepts when slot_free = !o_ds_valid || i_ds_ready.
  - On accept, the slot loads size, frag, last and src_id, and sets valid the next cycle.
  - o_ds_valid clears when i_ds_ready=1 and no new accept occurs in the same cycle.
- Transfer rule: upstream fragment accepted iff o_us_ready[g] && i_us_valid[g]. At most one o_us_ready bit is ever high.
- IDLE state:
  - g = first index with i_us_valid=1, searching cyclically from r_rr_ptr+1.
  - o_us_ready[g] = slot_free; zero-cycle grant.
  - If nothing is valid, all ready=0.
  - On accept with last=0: go to LOCKED, r_lock_id=g.
  - On accept with last=1: stay IDLE, r_rr_ptr=g.
- LOCKED state:
  - o_us_ready[r_lock_id] = slot_free; other sources are ignored even if valid.
  - On accept with last=1: go to IDLE, r_rr_ptr=r_lock_id.
- Size rules:
  - Size 0 is legal and forwarded unchanged; it is used for a bare last marker.
  - Clipping is min(size, S_MAX_IN).
- Fairness: with all N_SRC requesting single-fragment packets continuously, grants rotate 0,1,...,N_SRC-1,0,...
- Throughput: back-to-back packets from different sources incur no bubble; 1 fragment/cycle when i_ds_ready is held high.
- Reset mid-packet: lock and the held fragment are discarded; arbitration restarts from source 0. The upstream must restart its packet.
- Upstream contract: i_us_valid is held stable until accepted. The block does not check this.

Optional Feature:
- Macro FRAGMENT_RR_ARBITER_STATS_EN.
- When defined:
  - Adds output o_stat_elem_cnt [N_SRC][32]: per-source count of accepted elements (clipped size).
  - Adds output o_stat_pkt_cnt [N_SRC][32]: per-source count of accepted last fragments.
  - Both counters saturate at 2^32-1 and reset to 0.
- When undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Package fragment_rr_arbiter_pkg holds:
  - state enum {IDLE, LOCKED};
  - function clip_size(size, s_max) returning the clipped size.
- Sub-module rr_priority_picker: purely combinational. Given a request vector and a start pointer, returns a one-hot grant and its index. It is parameterised by N_SRC so other arbiters can reuse it.

Test Plan:
- Reset release, sources 0 and 2 both valid with last=1 -> source 0 granted first, then 2. o_ds_src_id shows 0 then 2, one cycle after each accept.
- Source 1 sends 3 fragments of sizes 4, 4, 2 (last on the 3rd) while source 0 is valid -> source 0 is ignored until source 1's 3rd fragment is accepted, then source 0 is granted the next cycle.
- All 4 sources request single-fragment packets continuously, i_ds_ready=1 -> grant order 0,1,2,3,0,1, with o_ds_valid continuously 1.
- i_ds_ready toggled 1,0,0,1 during a packet -> no fragment lost or duplicated; o_us_ready low whenever the slot is full and i_ds_ready=0.
- Size input 7 with S_MAX_IN=4 (width 3) -> o_ds_size=4. Size 0 with last=1 -> forwarded with o_ds_size=0, and the lock is released.
- i_sync_rst asserted while LOCKED on source 2 with o_ds_valid=1 -> next cycle o_ds_valid=0 and all ready=0. After release, source 0 wins against source 2.
